alarm_controller: RTL

ALARM_CONTROLLER -- requirements
Module: alarm_controller

---
 rtl/alarm_pkg.sv | 37 +++
 rtl/time_param_store.sv | 57 +++++
 rtl/alarm_controller.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// Shared definitions for the car alarm controller: state encoding, timer slot
// selection codes and the timer count width.
package alarm_pkg;

    localparam int unsigned TIME_W = 32'd4;

    typedef enum logic [2:0] {
        ST_ARMED      = 3'd0,
        ST_TRIGGERED  = 3'd1,
        ST_SOUND      = 3'd2,
        ST_SOUND_HOLD = 3'd3,
        ST_DISARMED   = 3'd4,
        ST_WAIT_DOOR  = 3'd5,
        ST_ARMING     = 3'd6
    } alarm_state_e;

    typedef enum logic [1:0] {
        SEL_ARM       = 2'd0,
        SEL_DRIVER    = 2'd1,
        SEL_PASSENGER = 2'd2,
        SEL_ALARM     = 2'd3
    } time_sel_e;

    // Progress of the driver-door closed -> open -> closed walk-away gesture.
    localparam logic [1:0] WALK_WAIT_CLOSED = 2'd0;
    localparam logic [1:0] WALK_WAIT_OPEN   = 2'd1;
    localparam logic [1:0] WALK_WAIT_SHUT   = 2'd2;

    function automatic logic is_alert(input alarm_state_e s);
        return (s == ST_TRIGGERED) || (s == ST_SOUND) || (s == ST_SOUND_HOLD);
    endfunction

    function automatic logic is_siren(input alarm_state_e s);
        return (s == ST_SOUND) || (s == ST_SOUND_HOLD);
    endfunction

endpackage

// File: rtl/time_param_store.sv
// Four programmable 4-bit timer counts (arm, driver, passenger, alarm) with
// reset defaults, a single write port and a combinational read mux.
module time_param_store
    import alarm_pkg::*;
#(
    parameter logic [TIME_W-1:0] ARM_DEFAULT       = 4'd6,
    parameter logic [TIME_W-1:0] DRIVER_DEFAULT    = 4'd8,
    parameter logic [TIME_W-1:0] PASSENGER_DEFAULT = 4'd15,
    parameter logic [TIME_W-1:0] ALARM_DEFAULT     = 4'd10
) (
    input  logic              clock_25mhz,
    input  logic              reset_n,
    input  logic              wr_en,
    input  time_sel_e         wr_sel,
    input  logic [TIME_W-1:0] wr_data,
    input  time_sel_e         rd_sel,
    output logic [TIME_W-1:0] rd_data
);

    logic [TIME_W-1:0] arm_r;
    logic [TIME_W-1:0] driver_r;
    logic [TIME_W-1:0] passenger_r;
    logic [TIME_W-1:0] alarm_r;

    // Slot registers: defaults at reset, one slot rewritten per write pulse.
    always_ff @(posedge clock_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            arm_r       <= ARM_DEFAULT;
            driver_r    <= DRIVER_DEFAULT;
            passenger_r <= PASSENGER_DEFAULT;
            alarm_r     <= ALARM_DEFAULT;
        end else if (wr_en) begin
            case (wr_sel)
                SEL_ARM:       arm_r       <= wr_data;
                SEL_DRIVER:    driver_r    <= wr_data;
                SEL_PASSENGER: passenger_r <= wr_data;
                SEL_ALARM:     alarm_r     <= wr_data;
                default:       arm_r       <= arm_r;
            endcase
        end else begin
            arm_r <= arm_r;
        end
    end

    // Read mux.
    always_comb begin
        rd_data = arm_r;
        case (rd_sel)
            SEL_ARM:       rd_data = arm_r;
            SEL_DRIVER:    rd_data = driver_r;
            SEL_PASSENGER: rd_data = passenger_r;
            SEL_ALARM:     rd_data = alarm_r;
            default:       rd_data = arm_r;
        endcase
    end

endmodule

// File: rtl/alarm_controller.sv
// Car anti-theft alarm FSM driving an external 0.1 s timer, siren and status LED.
// Optional fuel-pump interlock enabled by defining ALARM_FUEL_PUMP_EN.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int unsigned BLINK_HALF_PERIOD   = 32'd12500000,
    parameter int unsigned T_ARM_DEFAULT       = 32'd6,
    parameter int unsigned T_DRIVER_DEFAULT    = 32'd8,
    parameter int unsigned T_PASSENGER_DEFAULT = 32'd15,
    parameter int unsigned T_ALARM_DEFAULT     = 32'd10
) (
    input  logic              clock_25mhz,
    input  logic              reset_n,
    input  logic              ignition,
    input  logic              driver_door,
    input  logic              passenger_door,
    input  logic              hidden_switch,
    input  logic              brake_pedal,
    input  logic              reprogram,
    input  logic [1:0]        time_param_sel,
    input  logic [TIME_W-1:0] time_value,
    input  logic              expired,
    output logic              start_timer,
    output logic [TIME_W-1:0] value,
    output logic              siren,
    output logic              status_indicator,
    output logic              fuel_pump_power,
    output logic [2:0]        state_out
);

    localparam int unsigned BLINK_W = (BLINK_HALF_PERIOD > 32'd1) ? $clog2(BLINK_HALF_PERIOD) : 32'd1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF_PERIOD - 32'd1);

    alarm_state_e      state_r;
    alarm_state_e      next_state_s;
    logic              live_r;
    logic              start_s;
    time_sel_e         start_sel_s;
    logic [1:0]        walk_r;
    logic [1:0]        walk_next_s;
    logic [1:0]        guard_r;
    logic              expired_ok_s;
    logic              door_open_s;
    logic              reprog_take_s;
    logic [TIME_W-1:0] rd_data_s;
    logic [BLINK_W-1:0] blink_cnt_r;
    logic              status_r;
    logic              siren_r;
    logic              start_r;
    logic [TIME_W-1:0] value_r;
    logic              fuel_r;

    // live_r holds off the first edge after reset release so no pulse appears there.
    assign reprog_take_s = reprogram & live_r;
    assign door_open_s   = driver_door | passenger_door;
    assign expired_ok_s  = expired & (guard_r == 2'd0);

    time_param_store #(
        .ARM_DEFAULT      (TIME_W'(T_ARM_DEFAULT)),
        .DRIVER_DEFAULT   (TIME_W'(T_DRIVER_DEFAULT)),
        .PASSENGER_DEFAULT(TIME_W'(T_PASSENGER_DEFAULT)),
        .ALARM_DEFAULT    (TIME_W'(T_ALARM_DEFAULT))
    ) u_store (
        .clock_25mhz(clock_25mhz),
        .reset_n    (reset_n),
        .wr_en      (reprog_take_s),
        .wr_sel     (time_sel_e'(time_param_sel)),
        .wr_data    (time_value),
        .rd_sel     (start_sel_s),
        .rd_data    (rd_data_s)
    );

    // Next-state, timer start request and walk-away gesture tracking.
    always_comb begin
        next_state_s = state_r;
        start_s      = 1'b0;
        start_sel_s  = SEL_ARM;
        walk_next_s  = WALK_WAIT_CLOSED;
        if (!live_r) begin
            next_state_s = state_r;
        end else if (reprogram) begin
            next_state_s = ST_ARMED;
        end else begin
            case (state_r)
                ST_ARMED: begin
                    if (driver_door) begin
                        next_state_s = ST_TRIGGERED;
                        start_s      = 1'b1;
                        start_sel_s  = SEL_DRIVER;
                    end else if (passenger_door) begin
                        next_state_s = ST_TRIGGERED;
                        start_s      = 1'b1;
                        start_sel_s  = SEL_PASSENGER;
                    end else begin
                        next_state_s = ST_ARMED;
                    end
                end
                ST_TRIGGERED: begin
                    if (ignition) begin
                        next_state_s = ST_DISARMED;
                    end else if (expired_ok_s) begin
                        next_state_s = ST_SOUND;
                    end else begin
                        next_state_s = ST_TRIGGERED;
                    end
                end
                ST_SOUND: begin
                    if (!door_open_s) begin
                        next_state_s = ST_SOUND_HOLD;
                        start_s      = 1'b1;
                        start_sel_s  = SEL_ALARM;
                    end else begin
                        next_state_s = ST_SOUND;
                    end
                end
                ST_SOUND_HOLD: begin
                    if (door_open_s) begin
                        next_state_s = ST_SOUND;
                    end else if (expired_ok_s) begin
                        next_state_s = ST_ARMED;
                    end else begin
                        next_state_s = ST_SOUND_HOLD;
                    end
                end
                ST_DISARMED: begin
                    if (!ignition) begin
                        next_state_s = ST_WAIT_DOOR;
                    end else begin
                        next_state_s = ST_DISARMED;
                    end
                end
                ST_WAIT_DOOR: begin
                    if (ignition) begin
                        next_state_s = ST_DISARMED;
                    end else begin
                        case (walk_r)
                            WALK_WAIT_CLOSED: walk_next_s = driver_door ? WALK_WAIT_CLOSED : WALK_WAIT_OPEN;
                            WALK_WAIT_OPEN:   walk_next_s = driver_door ? WALK_WAIT_SHUT : WALK_WAIT_OPEN;
                            WALK_WAIT_SHUT: begin
                                if (!driver_door) begin
                                    next_state_s = ST_ARMING;
                                    start_s      = 1'b1;
                                    start_sel_s  = SEL_ARM;
                                end else begin
                                    walk_next_s = WALK_WAIT_SHUT;
                                end
                            end
                            default: walk_next_s = WALK_WAIT_CLOSED;
                        endcase
                    end
                end
                ST_ARMING: begin
                    if (ignition) begin
                        next_state_s = ST_DISARMED;
                    end else if (door_open_s) begin
                        next_state_s = ST_WAIT_DOOR;
                    end else if (expired_ok_s) begin
                        next_state_s = ST_ARMED;
                    end else begin
                        next_state_s = ST_ARMING;
                    end
                end
                default: next_state_s = ST_ARMED;
            endcase
        end
    end

    // State, timer interface and registered outputs; guard masks expired for two cycles after a start.
    always_ff @(posedge clock_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_ARMED;
            live_r  <= 1'b0;
            walk_r  <= WALK_WAIT_CLOSED;
            guard_r <= 2'd0;
            start_r <= 1'b0;
            value_r <= '0;
            siren_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            live_r  <= 1'b1;
            walk_r  <= walk_next_s;
            start_r <= start_s;
            siren_r <= is_siren(next_state_s);
            if (start_s) begin
                value_r <= rd_data_s;
                guard_r <= 2'd2;
            end else if (guard_r != 2'd0) begin
                guard_r <= guard_r - 2'd1;
            end else begin
                guard_r <= 2'd0;
            end
        end
    end

    // Status LED: blinks while armed (phase restarts on entry), solid during an alert.
    always_ff @(posedge clock_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_r <= '0;
            status_r    <= 1'b0;
        end else if (next_state_s == ST_ARMED) begin
            if ((state_r != ST_ARMED) || reprog_take_s) begin
                blink_cnt_r <= '0;
                status_r    <= 1'b0;
            end else if (blink_cnt_r == BLINK_LAST) begin
                blink_cnt_r <= '0;
                status_r    <= ~status_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + BLINK_W'(32'd1);
            end
        end else begin
            blink_cnt_r <= '0;
            status_r    <= is_alert(next_state_s);
        end
    end

`ifdef ALARM_FUEL_PUMP_EN
    // Fuel pump latches on with ignition plus the hidden switch and brake together.
    always_ff @(posedge clock_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            fuel_r <= 1'b0;
        end else if (!ignition) begin
            fuel_r <= 1'b0;
        end else if (hidden_switch && brake_pedal) begin
            fuel_r <= 1'b1;
        end else begin
            fuel_r <= fuel_r;
        end
    end
`else
    logic fuel_unused_s;
    assign fuel_unused_s = hidden_switch ^ brake_pedal;

    // Interlock not built: pump stays off.
    always_ff @(posedge clock_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            fuel_r <= 1'b0;
        end else begin
            fuel_r <= 1'b0;
        end
    end
`endif

    assign start_timer      = start_r;
    assign value            = value_r;
    assign siren            = siren_r;
    assign status_indicator = status_r;
    assign fuel_pump_power  = fuel_r;
    assign state_out        = state_r;

endmodule
